// File: rtl/bram_stream_loader.sv
// BRAM preload engine: writes a valid/ready word stream into a single-port memory,
// then reads the same region back and compares the read and write checksums.
module bram_stream_loader #(
  parameter int          BRAM_ADDR_WIDTH = 17,
  parameter int          BRAM_DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [BRAM_ADDR_WIDTH:0]   word_count,
  input  logic [BRAM_DATA_WIDTH-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [31:0]                bram_addr_a,
  output logic                       bram_clk_a,
  output logic [BRAM_DATA_WIDTH-1:0] bram_wrdata_a,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_rddata_a,
  output logic                       bram_en_a,
  output logic                       bram_rst_a,
  output logic [3:0]                 bram_we_a,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [BRAM_DATA_WIDTH-1:0] checksum
);

  localparam int            CW    = BRAM_ADDR_WIDTH + 1;
  localparam int            PAD   = 32 - CW - 2;
  localparam logic [CW-1:0] MAX_N = {1'b1, {BRAM_ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0] ONE   = {{BRAM_ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                     state_r, state_next_s;
  logic [CW-1:0]              n_r, idx_r;
  logic [BRAM_DATA_WIDTH-1:0] wsum_r, rsum_r, rsum_next_s, checksum_r;
  logic                       rd_pend_r, error_r;
  logic                       accept_s, xfer_s, issue_s, last_s;
  logic                       ready_s, en_s;
  logic [3:0]                 we_s;
  logic [31:0]                idx_addr_s;

  assign last_s      = (idx_r == (n_r - ONE));
  assign idx_addr_s  = BASE_ADDR + {{PAD{1'b0}}, idx_r, 2'b00};
  assign rsum_next_s = rd_pend_r ? (rsum_r + bram_rddata_a) : rsum_r;

  // Next-state decode and combinational memory-port drive
  always_comb begin
    state_next_s  = state_r;
    ready_s       = 1'b0;
    en_s          = 1'b0;
    we_s          = 4'h0;
    bram_addr_a   = BASE_ADDR;
    bram_wrdata_a = {BRAM_DATA_WIDTH{1'b0}};
    accept_s      = 1'b0;
    xfer_s        = 1'b0;
    issue_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (word_count == {CW{1'b0}}) begin
            state_next_s = DONE;
          end else begin
            state_next_s = WRITE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITE: begin
        ready_s = 1'b1;
        if (s_valid) begin
          xfer_s        = 1'b1;
          en_s          = 1'b1;
          we_s          = 4'hF;
          bram_addr_a   = idx_addr_s;
          bram_wrdata_a = s_data;
          if (last_s) begin
            state_next_s = READ;
          end else begin
            state_next_s = WRITE;
          end
        end else begin
          state_next_s = WRITE;
        end
      end
      READ: begin
        en_s        = 1'b1;
        issue_s     = 1'b1;
        bram_addr_a = idx_addr_s;
        if (last_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = READ;
        end
      end
      DRAIN:   state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Reset held low suppresses any port activity even before the state register clears
  assign s_ready    = ready_s & reset;
  assign bram_en_a  = en_s & reset;
  assign bram_we_a  = we_s & {4{reset}};
  assign bram_clk_a = clk;
  assign bram_rst_a = ~reset;
  assign busy       = (state_r != IDLE);
  assign done       = (state_r == DONE);
  assign error      = error_r;
  assign checksum   = checksum_r;

  // State, word counter, running sums and held result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      n_r        <= {CW{1'b0}};
      idx_r      <= {CW{1'b0}};
      wsum_r     <= {BRAM_DATA_WIDTH{1'b0}};
      rsum_r     <= {BRAM_DATA_WIDTH{1'b0}};
      rd_pend_r  <= 1'b0;
      error_r    <= 1'b0;
      checksum_r <= {BRAM_DATA_WIDTH{1'b0}};
    end else begin
      state_r   <= state_next_s;
      rd_pend_r <= issue_s;
      if (accept_s) begin
        n_r        <= (word_count > MAX_N) ? MAX_N : word_count;
        idx_r      <= {CW{1'b0}};
        wsum_r     <= {BRAM_DATA_WIDTH{1'b0}};
        rsum_r     <= {BRAM_DATA_WIDTH{1'b0}};
        error_r    <= 1'b0;
        checksum_r <= {BRAM_DATA_WIDTH{1'b0}};
      end else begin
        rsum_r <= rsum_next_s;
        if (xfer_s) begin
          wsum_r <= wsum_r + s_data;
        end
        if (xfer_s || issue_s) begin
          idx_r <= last_s ? {CW{1'b0}} : (idx_r + ONE);
        end
        // The last read word lands during DRAIN, so fold it in before comparing
        if (state_r == DRAIN) begin
          error_r    <= (rsum_next_s != wsum_r);
          checksum_r <= wsum_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_stream_loader.sv
// Self-checking bench for bram_stream_loader: table rows plus random loads against
// an event-list reference model, with a mid-load reset sequence.
module tb_bram_stream_loader;

  localparam int          AW    = 17;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0007_FFFC;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
  } ev_t;

  typedef struct {
    int          wc;
    int          mode;
    bit          fixed;
    bit          corr;
    bit          stray;
    bit          s;
    int          done;
    bit          cg;
    logic [31:0] cks;
    bit          err;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset, start0, start1, s_valid;
  logic [AW:0]   word_count;
  logic [31:0]   s_data;
  logic          s_ready0, s_ready1, clk_a0, clk_a1, en0, en1, rst_a0, rst_a1;
  logic          busy0, busy1, done0, done1, error0, error1;
  logic [31:0]   addr0, addr1, wrdata0, wrdata1, cks0, cks1;
  logic [31:0]   rddata0 = 32'd0, rddata1 = 32'd0;
  logic [3:0]    we0, we1;
  logic          sel = 1'b0, corrupt = 1'b0;
  logic          m_s_ready, m_en, m_busy, m_done, m_error, m_rst;
  logic [3:0]    m_we;
  logic [31:0]   m_addr, m_wrdata, m_cks;
  logic [31:0]   mem0 [0:(1<<AW)-1];
  logic [31:0]   mem1 [0:(1<<AW)-1];
  int            checks = 0, errors = 0, cyc = 0;
  ev_t           wr_q[$], rd_q[$], dn_q[$];
  vec_t          tbl[9];

  always #5 clk = ~clk;

  bram_stream_loader #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(32), .BASE_ADDR(BASE0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .word_count(word_count), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready0), .bram_addr_a(addr0), .bram_clk_a(clk_a0),
    .bram_wrdata_a(wrdata0), .bram_rddata_a(rddata0), .bram_en_a(en0), .bram_rst_a(rst_a0),
    .bram_we_a(we0), .busy(busy0), .done(done0), .error(error0), .checksum(cks0));

  bram_stream_loader #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(32), .BASE_ADDR(BASE1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .word_count(word_count), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready1), .bram_addr_a(addr1), .bram_clk_a(clk_a1),
    .bram_wrdata_a(wrdata1), .bram_rddata_a(rddata1), .bram_en_a(en1), .bram_rst_a(rst_a1),
    .bram_we_a(we1), .busy(busy1), .done(done1), .error(error1), .checksum(cks1));

  assign m_s_ready = sel ? s_ready1 : s_ready0;
  assign m_en      = sel ? en1      : en0;
  assign m_we      = sel ? we1      : we0;
  assign m_addr    = sel ? addr1    : addr0;
  assign m_wrdata  = sel ? wrdata1  : wrdata0;
  assign m_busy    = sel ? busy1    : busy0;
  assign m_done    = sel ? done1    : done0;
  assign m_error   = sel ? error1   : error0;
  assign m_cks     = sel ? cks1     : cks0;
  assign m_rst     = sel ? rst_a1   : rst_a0;

  // Memory models: 1-cycle read latency; mem0 can corrupt word 1 on readback
  always @(posedge clk) begin
    if (en0) begin
      if (we0 == 4'hF) mem0[addr0[AW+1:2]] <= wrdata0;
      if (corrupt && addr0[AW+1:2] == 17'd1) rddata0 <= mem0[addr0[AW+1:2]] ^ 32'h0000_0100;
      else rddata0 <= mem0[addr0[AW+1:2]];
    end
    if (en1) begin
      if (we1 == 4'hF) mem1[addr1[AW+1:2]] <= wrdata1;
      rddata1 <= mem1[addr1[AW+1:2]];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Port monitor for the selected instance
  always @(negedge clk) begin
    ev_t e;
    e.cyc = cyc; e.addr = m_addr; e.data = m_wrdata; e.we = m_we;
    if (m_en && m_we != 4'h0) wr_q.push_back(e);
    if (m_en && m_we == 4'h0) rd_q.push_back(e);
    if (m_done) begin
      e.addr = {31'd0, m_error}; e.data = m_cks;
      dn_q.push_back(e);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_load(input int id, input vec_t v);
    logic [31:0] d[$];
    bit          pat[$];
    ev_t         ew[$], er[$], e;
    int          n, t0, l, k, ptr, done_rel, last, wb, rb, db, exp_done;
    logic [31:0] base, sum, exp_cks;
    n    = (v.wc > (1 << AW)) ? (1 << AW) : v.wc;
    base = v.s ? BASE1 : BASE0;
    for (int i = 0; i < n; i++) d.push_back(v.fixed ? 32'(i + 1) : $urandom);
    for (int i = 0; i < 64; i++)
      pat.push_back(v.mode == 0 ? 1'b1 : v.mode == 1 ? (i % 2 == 0) :
                    (i >= 40 ? 1'b1 : 1'($urandom_range(0, 1))));
    // Reference: k-th accepted word goes to base+4k in the k-th valid cycle
    sum = 32'd0; k = 0; l = 0;
    for (int i = 0; i < 64 && k < n; i++) begin
      if (pat[i]) begin
        e.cyc = i + 1; e.addr = base + 32'(4 * k); e.data = d[k]; e.we = 4'hF;
        ew.push_back(e); sum += d[k]; k++; l = i + 1;
      end
    end
    for (int j = 0; j < n; j++) begin
      e.cyc = l + 1 + j; e.addr = base + 32'(4 * j); e.data = 32'd0; e.we = 4'h0;
      er.push_back(e);
    end
    done_rel = (n == 0) ? 1 : l + n + 2;
    exp_done = (v.done >= 0) ? v.done : done_rel;
    exp_cks  = v.cg ? v.cks : sum;
    last     = done_rel + 4;
    sel = v.s; corrupt = v.corr;
    wb = wr_q.size(); rb = rd_q.size(); db = dn_q.size();
    @(posedge clk); #1;
    t0 = cyc;
    if (v.s) start1 = 1'b1; else start0 = 1'b1;
    word_count = (AW + 1)'(v.wc); s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    ptr = 0;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      if (v.stray && c == 2) begin
        if (v.s) start1 = 1'b1; else start0 = 1'b1;
        word_count = (AW + 1)'(5);
      end
      s_valid = (c <= 64) ? pat[c-1] : 1'b0;
      s_data  = (ptr < n) ? d[ptr] : $urandom;
      @(negedge clk);
      if (c == 1) begin
        check($sformatf("r%0d_busy_c1", id), m_busy, 1'b1);
        check($sformatf("r%0d_err_clr", id), m_error, 1'b0);
        check($sformatf("r%0d_cks_clr", id), m_cks, 32'd0);
      end
      if (s_valid && m_s_ready) ptr++;
    end
    check($sformatf("r%0d_wr_cnt", id), wr_q.size() - wb, ew.size());
    for (int i = 0; i < ew.size() && wb + i < wr_q.size(); i++) begin
      check($sformatf("r%0d_wr%0d_cyc", id, i), wr_q[wb+i].cyc - t0, ew[i].cyc);
      check($sformatf("r%0d_wr%0d_addr", id, i), wr_q[wb+i].addr, ew[i].addr);
      check($sformatf("r%0d_wr%0d_data", id, i), wr_q[wb+i].data, ew[i].data);
      check($sformatf("r%0d_wr%0d_we", id, i), wr_q[wb+i].we, 4'hF);
    end
    check($sformatf("r%0d_rd_cnt", id), rd_q.size() - rb, er.size());
    for (int i = 0; i < er.size() && rb + i < rd_q.size(); i++) begin
      check($sformatf("r%0d_rd%0d_cyc", id, i), rd_q[rb+i].cyc - t0, er[i].cyc);
      check($sformatf("r%0d_rd%0d_addr", id, i), rd_q[rb+i].addr, er[i].addr);
    end
    check($sformatf("r%0d_done_cnt", id), dn_q.size() - db, 1);
    if (dn_q.size() > db) begin
      check($sformatf("r%0d_done_cyc", id), dn_q[db].cyc - t0, exp_done);
      check($sformatf("r%0d_done_err", id), dn_q[db].addr, {31'd0, v.err});
      check($sformatf("r%0d_done_cks", id), dn_q[db].data, exp_cks);
    end
    check($sformatf("r%0d_idle_busy", id), m_busy, 1'b0);
    check($sformatf("r%0d_held_err", id), m_error, v.err);
    check($sformatf("r%0d_held_cks", id), m_cks, exp_cks);
  endtask

  initial begin
    int   t0, wb, rb, db, late_rd, late_wr;
    vec_t v;
    reset = 1'b0; start0 = 1'b0; start1 = 1'b0; word_count = '0;
    s_valid = 1'b0; s_data = 32'd0;
    //            wc mode fixed corr stray s  done cg  cks     err
    tbl[0] = '{4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 10, 1'b1, 32'd10, 1'b0};
    tbl[1] = '{3, 1, 1'b1, 1'b0, 1'b0, 1'b0, 10, 1'b1, 32'd6,  1'b0};
    tbl[2] = '{2, 0, 1'b0, 1'b1, 1'b0, 1'b0, 6,  1'b0, 32'd0,  1'b1};
    tbl[3] = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1,  1'b1, 32'd0,  1'b0};
    tbl[4] = '{2, 0, 1'b1, 1'b0, 1'b0, 1'b1, 6,  1'b1, 32'd3,  1'b0};
    tbl[5] = '{5, 2, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 32'd0,  1'b0};
    tbl[6] = '{7, 2, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 32'd0,  1'b0};
    tbl[7] = '{6, 0, 1'b0, 1'b1, 1'b1, 1'b0, 14, 1'b0, 32'd0,  1'b1};
    tbl[8] = '{1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 4,  1'b1, 32'd1,  1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", s_ready0, 1'b0);
    check("rst_en", en0, 1'b0);
    check("rst_we", we0, 4'h0);
    check("rst_busy_done_err", {busy0, done0, error0}, 3'b000);
    check("rst_addr0", addr0, BASE0);
    check("rst_addr1", addr1, BASE1);
    check("rst_wrdata", wrdata0, 32'd0);
    check("rst_cks", cks0, 32'd0);
    check("rst_bram_rst", rst_a0, 1'b1);
    @(posedge clk); #1 reset = 1'b1;

    for (int i = 0; i < 9; i++) run_load(i, tbl[i]);

    // Reset asserted during the read-back phase of an 8-word load
    sel = 1'b0; corrupt = 1'b0;
    wb = wr_q.size(); rb = rd_q.size(); db = dn_q.size();
    @(posedge clk); #1;
    t0 = cyc; start0 = 1'b1; word_count = (AW + 1)'(8); s_valid = 1'b1; s_data = 32'h100;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      start0 = 1'b0; s_data = 32'h100 + 32'(c);
      if (c == 11) reset = 1'b0;
    end
    @(negedge clk);
    check("mid_rst_bram_rst", m_rst, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("mid_rst_en_we", {en0, we0}, 5'd0);
    check("mid_rst_busy_done", {busy0, done0, s_ready0}, 3'b000);
    s_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    late_rd = 0; late_wr = 0;
    for (int i = rb; i < rd_q.size(); i++) if (rd_q[i].cyc - t0 >= 12) late_rd++;
    for (int i = wb; i < wr_q.size(); i++) if (wr_q[i].cyc - t0 >= 9) late_wr++;
    check("mid_rst_no_done", dn_q.size() - db, 0);
    check("mid_rst_no_reads", late_rd, 0);
    check("mid_rst_no_writes", late_wr, 0);

    for (int r = 0; r < 6; r++) begin
      v.wc    = $urandom_range(1, 12);
      v.mode  = $urandom_range(0, 2);
      v.fixed = 1'b0;
      v.corr  = 1'($urandom_range(0, 1));
      v.stray = (v.wc >= 2) && ($urandom_range(0, 1) == 1);
      v.s     = 1'b0;
      v.done  = -1;
      v.cg    = 1'b0;
      v.cks   = 32'd0;
      v.err   = v.corr && (v.wc >= 2);
      run_load(20 + r, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
